// File: rtl/riscv_id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_id_stage_if
//  Brief    : Instruction-in, operands-out and register writeback bundle for
//             the decode/operand-fetch stage.
//  Revision : 1.0  initial release
// ============================================================================
interface riscv_id_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [3:0]      out_alu_op;
  logic [4:0]      out_rd;
  logic            out_illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_a, out_b, out_alu_op, out_rd, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/riscv_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_id_stage
//  Brief    : RV32I R-type/OP-IMM decode and register-file operand fetch
//             behind a valid/ready output register. Optional macro
//             ID_WB_BYPASS_EN forwards same-cycle writeback data to operands.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  wire logic           clk,
  input  wire logic           rst,
  riscv_id_stage_if.slave     bus
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_F7_BASE    = 7'b0000000;
  localparam logic [6:0] c_F7_ALT     = 7'b0100000;

  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_SUB  = 4'b0001;
  localparam logic [3:0] c_ALU_AND  = 4'b0010;
  localparam logic [3:0] c_ALU_OR   = 4'b0011;
  localparam logic [3:0] c_ALU_XOR  = 4'b0100;
  localparam logic [3:0] c_ALU_SLT  = 4'b0101;
  localparam logic [3:0] c_ALU_SLL  = 4'b0110;
  localparam logic [3:0] c_ALU_SRL  = 4'b0111;
  localparam logic [3:0] c_ALU_SRA  = 4'b1000;
  localparam logic [3:0] c_ALU_SLTU = 4'b1001;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_valid;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [3:0]      r_alu_op;
  logic [4:0]      r_rd;
  logic            r_illegal;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_imm_shamt;
  logic [3:0]      w_alu_op;
  logic            w_illegal;
  logic            w_use_imm;
  logic            w_use_shamt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_rd;
  logic            w_fire;

  assign w_opcode    = bus.in_instr[6:0];
  assign w_funct3    = bus.in_instr[14:12];
  assign w_funct7    = bus.in_instr[31:25];
  assign w_rs1       = bus.in_instr[19:15];
  assign w_rs2       = bus.in_instr[24:20];
  assign w_imm_sext  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign w_imm_shamt = {{(XLEN-5){1'b0}}, bus.in_instr[24:20]};

  assign bus.in_ready = !r_valid || bus.out_ready;
  assign w_fire       = bus.in_valid && bus.in_ready;

  // Register file: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_rd != 5'd0)) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                     (bus.wb_en && (bus.wb_rd == w_rs1)) ? bus.wb_data : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                     (bus.wb_en && (bus.wb_rd == w_rs2)) ? bus.wb_data : r_regs[w_rs2];
`else
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
`endif

  always_comb begin
    w_alu_op    = c_ALU_ADD;
    w_illegal   = 1'b0;
    w_use_imm   = 1'b0;
    w_use_shamt = 1'b0;
    case (w_opcode)
      c_OPC_OP: begin
        case (w_funct3)
          3'b000: begin
            if (w_funct7 == c_F7_BASE)     w_alu_op = c_ALU_ADD;
            else if (w_funct7 == c_F7_ALT) w_alu_op = c_ALU_SUB;
            else                           w_illegal = 1'b1;
          end
          3'b101: begin
            if (w_funct7 == c_F7_BASE)     w_alu_op = c_ALU_SRL;
            else if (w_funct7 == c_F7_ALT) w_alu_op = c_ALU_SRA;
            else                           w_illegal = 1'b1;
          end
          default: begin
            w_illegal = (w_funct7 != c_F7_BASE);
            case (w_funct3)
              3'b001:  w_alu_op = c_ALU_SLL;
              3'b010:  w_alu_op = c_ALU_SLT;
              3'b011:  w_alu_op = c_ALU_SLTU;
              3'b100:  w_alu_op = c_ALU_XOR;
              3'b110:  w_alu_op = c_ALU_OR;
              default: w_alu_op = c_ALU_AND;
            endcase
          end
        endcase
      end
      c_OPC_OP_IMM: begin
        w_use_imm = 1'b1;
        case (w_funct3)
          3'b000: w_alu_op = c_ALU_ADD;
          3'b010: w_alu_op = c_ALU_SLT;
          3'b011: w_alu_op = c_ALU_SLTU;
          3'b100: w_alu_op = c_ALU_XOR;
          3'b110: w_alu_op = c_ALU_OR;
          3'b111: w_alu_op = c_ALU_AND;
          3'b001: begin
            w_use_shamt = 1'b1;
            w_alu_op    = c_ALU_SLL;
            w_illegal   = (w_funct7 != c_F7_BASE);
          end
          default: begin
            w_use_shamt = 1'b1;
            if (w_funct7 == c_F7_BASE)     w_alu_op = c_ALU_SRL;
            else if (w_funct7 == c_F7_ALT) w_alu_op = c_ALU_SRA;
            else                           w_illegal = 1'b1;
          end
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Illegal instructions still flow through, but with every payload field zeroed.
  always_comb begin
    w_a = w_rs1_val;
    w_b = w_use_shamt ? w_imm_shamt : (w_use_imm ? w_imm_sext : w_rs2_val);
    w_rd = bus.in_instr[11:7];
    if (w_illegal) begin
      w_a  = '0;
      w_b  = '0;
      w_rd = 5'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_op  <= 4'd0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
    end else if (w_fire) begin
      r_valid   <= 1'b1;
      r_a       <= w_a;
      r_b       <= w_b;
      r_alu_op  <= w_illegal ? c_ALU_ADD : w_alu_op;
      r_rd      <= w_rd;
      r_illegal <= w_illegal;
    end else if (bus.out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.out_valid   = r_valid;
  assign bus.out_a       = r_a;
  assign bus.out_b       = r_b;
  assign bus.out_alu_op  = r_alu_op;
  assign bus.out_rd      = r_rd;
  assign bus.out_illegal = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_id_stage
//  Brief    : Scoreboard bench for riscv_id_stage with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_id_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q[$];

  riscv_id_stage_if #(.XLEN(32)) bus ();

  riscv_id_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic [4:0] rd,
                              input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rd = rd; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: compares the presented output against the scoreboard head and pops on acceptance.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got valid output a=0x%08h rd=%0d, required no output",
                 bus.out_a, bus.out_rd);
      end else begin
        if ({bus.out_a, bus.out_b, bus.out_alu_op, bus.out_rd, bus.out_illegal} !== q[0]) begin
          errors++;
          $display("FAIL %s: got a=0x%08h b=0x%08h op=%0h rd=%0d ill=%0b, required a=0x%08h b=0x%08h op=%0h rd=%0d ill=%0b",
                   bus.out_ready ? "out_pop" : "out_hold",
                   bus.out_a, bus.out_b, bus.out_alu_op, bus.out_rd, bus.out_illegal,
                   q[0].a, q[0].b, q[0].op, q[0].rd, q[0].ill);
        end
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] instr, input exp_t e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, required 1");
    end else begin
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    @(posedge clk);
    #1;
    bus.wb_en = 1'b0;
  endtask

  initial begin
    int n;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.out_ready = 1'b1;
    bus.wb_en     = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_a", bus.out_a, 32'd0);
    chk("rst_out_b", bus.out_b, 32'd0);
    chk("rst_out_alu_op", {28'd0, bus.out_alu_op}, 32'd0);
    chk("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    wb(5'd1, 32'd15);
    wb(5'd2, 32'd10);

    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), mk(32'd15, 32'd10, 4'h0, 5'd3, 1'b0));
    chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    send(enc_i(12'hFFB, 5'd1, 3'b000, 5'd4), mk(32'd15, 32'hFFFFFFFB, 4'h0, 5'd4, 1'b0));
    send(enc_i(12'h007, 5'd1, 3'b010, 5'd5), mk(32'd15, 32'd7, 4'h5, 5'd5, 1'b0));
    send(enc_i(12'h403, 5'd1, 3'b101, 5'd6), mk(32'd15, 32'd3, 4'h8, 5'd6, 1'b0));
    send(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd9), mk(32'd15, 32'd10, 4'h1, 5'd9, 1'b0));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd16), mk(32'd15, 32'd10, 4'h9, 5'd16, 1'b0));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd17), mk(32'd15, 32'd10, 4'h7, 5'd17, 1'b0));
    send(enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd18), mk(32'd15, 32'd10, 4'h8, 5'd18, 1'b0));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd19), mk(32'd15, 32'd10, 4'h6, 5'd19, 1'b0));
    send(enc_i(12'h7FF, 5'd1, 3'b100, 5'd20), mk(32'd15, 32'h000007FF, 4'h4, 5'd20, 1'b0));
    send(enc_i(12'hFFF, 5'd1, 3'b111, 5'd21), mk(32'd15, 32'hFFFFFFFF, 4'h2, 5'd21, 1'b0));
    send(enc_i(12'h01F, 5'd2, 3'b001, 5'd22), mk(32'd10, 32'd31, 4'h6, 5'd22, 1'b0));
    send(enc_i(12'h800, 5'd2, 3'b110, 5'd23), mk(32'd10, 32'hFFFFF800, 4'h3, 5'd23, 1'b0));
    send(enc_i(12'h001, 5'd1, 3'b011, 5'd24), mk(32'd15, 32'd1, 4'h9, 5'd24, 1'b0));
    // Illegal funct7 variants and an unknown opcode
    send(enc_i(12'h401, 5'd1, 3'b001, 5'd25), mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b1));
    send(enc_i(12'h023, 5'd1, 3'b101, 5'd26), mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b1));
    send(enc_r(7'h20, 5'd2, 5'd1, 3'b010, 5'd27), mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b1));
    send(enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd28), mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b1));
    send(32'h0000007F, mk(32'd0, 32'd0, 4'h0, 5'd0, 1'b1));

    // Back-pressure: hold AND in the output register for three cycles while OR waits.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd10), mk(32'd15, 32'd10, 4'h2, 5'd10, 1'b0));
    bus.in_valid = 1'b1;
    bus.in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd11);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd11), mk(32'd15, 32'd10, 4'h3, 5'd11, 1'b0));

    wb(5'd0, 32'h0000DEAD);
    send(enc_r(7'h00, 5'd2, 5'd0, 3'b110, 5'd8), mk(32'd0, 32'd10, 4'h3, 5'd8, 1'b0));

    // Writeback to x1 in the same cycle SUB reads it
    bus.wb_en   = 1'b1;
    bus.wb_rd   = 5'd1;
    bus.wb_data = 32'd20;
`ifdef ID_WB_BYPASS_EN
    send(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd7), mk(32'd20, 32'd10, 4'h1, 5'd7, 1'b0));
`else
    send(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd7), mk(32'd15, 32'd10, 4'h1, 5'd7, 1'b0));
`endif
    bus.wb_en = 1'b0;
    send(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd12), mk(32'd20, 32'd0, 4'h0, 5'd12, 1'b0));

    // Asynchronous reset while an instruction is held
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd14), mk(32'd20, 32'd10, 4'h4, 5'd14, 1'b0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_out_a", bus.out_a, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd15), mk(32'd0, 32'd0, 4'h0, 5'd15, 1'b0));

    n = 0;
    while (q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
